tcp_rx_app_msg_poller: RTL and testbench

- Receive-side counterpart of the TX message poller. It sits between the RX app-interface NoC unit and the per-flow RX pointer memories.
- It queues app "give me LEN bytes of flow F" requests. It polls each flow's app-read head pointer and engine commit pointer until LEN bytes are available in the RX payload buffer.
- It then emits message metadata (base pointer, len, reply destination) for the NoC unit to answer.
- Unsatisfied requests are re-queued round-robin.

---
 rtl/tcp_pkg.sv | 25 ++
 rtl/rx_poll_req_fifo.sv | 54 +++++
 rtl/tcp_rx_app_msg_poller.sv | 207 ++++++++++++++++++++
 tb/tb_tcp_rx_app_msg_poller.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkg.sv
// Shared types for the TCP RX app-message poller: request entry layout,
// poller FSM encoding and the default pointer/flow-id widths.
package tcp_pkg;
  localparam int FLOWID_W         = 8;
  localparam int RX_PAYLOAD_PTR_W = 14;
  localparam int XY_WIDTH         = 8;
  localparam int NOC_FBITS_WIDTH  = 4;

  typedef struct packed {
    logic [FLOWID_W-1:0]         flowid;
    logic [RX_PAYLOAD_PTR_W-1:0] len;
    logic [XY_WIDTH-1:0]         dst_x;
    logic [XY_WIDTH-1:0]         dst_y;
    logic [NOC_FBITS_WIDTH-1:0]  dst_fbits;
  } rx_req_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_EVAL    = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_REQUEUE = 3'd5
  } poll_state_e;
endpackage

// File: rtl/rx_poll_req_fifo.sv
// Circular queue of pending app read requests. A requeued entry and a new
// request may both be written in one cycle; the requeue takes the first slot.
module rx_poll_req_fifo
  import tcp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  rx_req_entry_t wr_data,
  input  logic          rq_en,
  input  rx_req_entry_t rq_data,
  input  logic          pop_en,
  output rx_req_entry_t head_data,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  rx_req_entry_t    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    new_slot;

  always_comb begin
    new_slot = rq_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + AW'(rq_en) + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_en);
    count_d  = count_q + CNT_W'(rq_en) + CNT_W'(wr_en) - CNT_W'(pop_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count are ever popped.
  always_ff @(posedge clk) begin
    if (rq_en) mem_q[wr_ptr_q] <= rq_data;
    if (wr_en) mem_q[new_slot] <= wr_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
endmodule

// File: rtl/tcp_rx_app_msg_poller.sv
// Polls per-flow RX head/commit pointers for queued app read requests and
// emits message metadata once enough payload bytes are available.
module tcp_rx_app_msg_poller
  import tcp_pkg::*;
#(
  parameter int FLOWID_W = tcp_pkg::FLOWID_W,
  parameter int PTR_W    = tcp_pkg::RX_PAYLOAD_PTR_W,
  parameter int Q_DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       src_poller_msg_req_val,
  input  logic [FLOWID_W-1:0]        src_poller_msg_req_flowid,
  input  logic [PTR_W-1:0]           src_poller_msg_req_len,
  input  logic [XY_WIDTH-1:0]        src_poller_msg_dst_x,
  input  logic [XY_WIDTH-1:0]        src_poller_msg_dst_y,
  input  logic [NOC_FBITS_WIDTH-1:0] src_poller_msg_dst_fbits,
  output logic                       poller_src_msg_req_rdy,
  output logic                       poller_msg_dst_meta_val,
  output logic [FLOWID_W-1:0]        poller_msg_dst_flowid,
  output logic [PTR_W:0]             poller_msg_dst_base_ptr,
  output logic [PTR_W-1:0]           poller_msg_dst_len,
  output logic [XY_WIDTH-1:0]        poller_msg_dst_dst_x,
  output logic [XY_WIDTH-1:0]        poller_msg_dst_dst_y,
  output logic [NOC_FBITS_WIDTH-1:0] poller_msg_dst_dst_fbits,
  input  logic                       dst_poller_msg_meta_rdy,
  output logic                       app_head_ptr_rd_req_val,
  output logic [FLOWID_W-1:0]        app_head_ptr_rd_req_addr,
  input  logic                       head_ptr_app_rd_req_rdy,
  input  logic                       head_ptr_app_rd_resp_val,
  input  logic [PTR_W:0]             head_ptr_app_rd_resp_data,
  output logic                       app_head_ptr_rd_resp_rdy,
  output logic                       app_commit_ptr_rd_req_val,
  output logic [FLOWID_W-1:0]        app_commit_ptr_rd_req_addr,
  input  logic                       commit_ptr_app_rd_req_rdy,
  input  logic                       commit_ptr_app_rd_resp_val,
  input  logic [PTR_W:0]             commit_ptr_app_rd_resp_data,
  output logic                       app_commit_ptr_rd_resp_rdy
);
  // All interfaces transfer on val && rdy in the same cycle; a raised val and
  // its data hold until accepted.
  localparam int QAW   = $clog2(Q_DEPTH);
  localparam int CNT_W = QAW + 1;

  poll_state_e      state_q, state_d;
  rx_req_entry_t    work_q, work_d;
  logic             inflight_q, inflight_d;
  logic             req_rdy_q, req_rdy_d;
  logic             head_req_val_q, head_req_val_d;
  logic             commit_req_val_q, commit_req_val_d;
  logic [FLOWID_W-1:0] rd_addr_q, rd_addr_d;
  logic             head_resp_rdy_q, head_resp_rdy_d;
  logic             commit_resp_rdy_q, commit_resp_rdy_d;
  logic [PTR_W:0]   head_ptr_q, head_ptr_d;
  logic [PTR_W:0]   commit_ptr_q, commit_ptr_d;
  logic             meta_val_q, meta_val_d;

  logic             wr_en, rq_en, pop_en;
  rx_req_entry_t    new_entry, fifo_head;
  logic [CNT_W-1:0] fifo_count, count_next;
  logic [CNT_W:0]   occ_next;
  logic [PTR_W:0]   avail;

  rx_poll_req_fifo #(
    .DEPTH (Q_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (new_entry),
    .rq_en     (rq_en),
    .rq_data   (work_q),
    .pop_en    (pop_en),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    new_entry = '{flowid:    src_poller_msg_req_flowid,
                  len:       src_poller_msg_req_len,
                  dst_x:     src_poller_msg_dst_x,
                  dst_y:     src_poller_msg_dst_y,
                  dst_fbits: src_poller_msg_dst_fbits};
    wr_en  = src_poller_msg_req_val && req_rdy_q;
    pop_en = (state_q == ST_IDLE) && (fifo_count != '0);
    rq_en  = (state_q == ST_REQUEUE);
    // Modular distance; the wrap bit makes a full buffer read as 2^PTR_W.
    avail  = commit_ptr_q - head_ptr_q;

    state_d           = state_q;
    work_d            = work_q;
    inflight_d        = inflight_q;
    head_req_val_d    = head_req_val_q;
    commit_req_val_d  = commit_req_val_q;
    rd_addr_d         = rd_addr_q;
    head_resp_rdy_d   = head_resp_rdy_q;
    commit_resp_rdy_d = commit_resp_rdy_q;
    head_ptr_d        = head_ptr_q;
    commit_ptr_d      = commit_ptr_q;
    meta_val_d        = meta_val_q;

    case (state_q)
      ST_IDLE: begin
        if (pop_en) begin
          work_d           = fifo_head;
          inflight_d       = 1'b1;
          head_req_val_d   = 1'b1;
          commit_req_val_d = 1'b1;
          rd_addr_d        = fifo_head.flowid;
          state_d          = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (head_req_val_q && head_ptr_app_rd_req_rdy)     head_req_val_d   = 1'b0;
        if (commit_req_val_q && commit_ptr_app_rd_req_rdy) commit_req_val_d = 1'b0;
        if (!head_req_val_d && !commit_req_val_d) begin
          head_resp_rdy_d   = 1'b1;
          commit_resp_rdy_d = 1'b1;
          state_d           = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (head_resp_rdy_q && head_ptr_app_rd_resp_val) begin
          head_ptr_d      = head_ptr_app_rd_resp_data;
          head_resp_rdy_d = 1'b0;
        end
        if (commit_resp_rdy_q && commit_ptr_app_rd_resp_val) begin
          commit_ptr_d      = commit_ptr_app_rd_resp_data;
          commit_resp_rdy_d = 1'b0;
        end
        if (!head_resp_rdy_d && !commit_resp_rdy_d) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (avail >= {1'b0, work_q.len}) begin
          meta_val_d = 1'b1;
          state_d    = ST_OUTPUT;
        end else begin
          state_d = ST_REQUEUE;
        end
      end
      ST_OUTPUT: begin
        if (dst_poller_msg_meta_rdy) begin
          meta_val_d = 1'b0;
          inflight_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_REQUEUE: begin
        inflight_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Queue entries plus the in-flight poll never exceed Q_DEPTH, so a
    // requeue always finds a free slot.
    count_next = fifo_count + CNT_W'(wr_en) + CNT_W'(rq_en) - CNT_W'(pop_en);
    occ_next   = {1'b0, count_next} + (CNT_W+1)'(inflight_d);
    req_rdy_d  = occ_next < (CNT_W+1)'(Q_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      work_q            <= '0;
      inflight_q        <= 1'b0;
      req_rdy_q         <= 1'b0;
      head_req_val_q    <= 1'b0;
      commit_req_val_q  <= 1'b0;
      rd_addr_q         <= '0;
      head_resp_rdy_q   <= 1'b0;
      commit_resp_rdy_q <= 1'b0;
      head_ptr_q        <= '0;
      commit_ptr_q      <= '0;
      meta_val_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      work_q            <= work_d;
      inflight_q        <= inflight_d;
      req_rdy_q         <= req_rdy_d;
      head_req_val_q    <= head_req_val_d;
      commit_req_val_q  <= commit_req_val_d;
      rd_addr_q         <= rd_addr_d;
      head_resp_rdy_q   <= head_resp_rdy_d;
      commit_resp_rdy_q <= commit_resp_rdy_d;
      head_ptr_q        <= head_ptr_d;
      commit_ptr_q      <= commit_ptr_d;
      meta_val_q        <= meta_val_d;
    end
  end

  assign poller_src_msg_req_rdy     = req_rdy_q;
  assign poller_msg_dst_meta_val    = meta_val_q;
  assign poller_msg_dst_flowid      = work_q.flowid;
  assign poller_msg_dst_base_ptr    = head_ptr_q;
  assign poller_msg_dst_len         = work_q.len;
  assign poller_msg_dst_dst_x       = work_q.dst_x;
  assign poller_msg_dst_dst_y       = work_q.dst_y;
  assign poller_msg_dst_dst_fbits   = work_q.dst_fbits;
  assign app_head_ptr_rd_req_val    = head_req_val_q;
  assign app_head_ptr_rd_req_addr   = rd_addr_q;
  assign app_head_ptr_rd_resp_rdy   = head_resp_rdy_q;
  assign app_commit_ptr_rd_req_val  = commit_req_val_q;
  assign app_commit_ptr_rd_req_addr = rd_addr_q;
  assign app_commit_ptr_rd_resp_rdy = commit_resp_rdy_q;
endmodule

// File: tb/tb_tcp_rx_app_msg_poller.sv
// Directed bench for tcp_rx_app_msg_poller with behavioural head/commit
// pointer memories whose request-ready and response latency are adjustable.
module tb_tcp_rx_app_msg_poller;
  localparam int FW = 8, PW = 14, XW = 8, FBW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req_val = 1'b0;
  logic [FW-1:0]  req_flowid = '0;
  logic [PW-1:0]  req_len = '0;
  logic [XW-1:0]  req_x = '0, req_y = '0;
  logic [FBW-1:0] req_f = '0;
  logic           req_rdy;
  logic           meta_val;
  logic [FW-1:0]  meta_flowid;
  logic [PW:0]    meta_base;
  logic [PW-1:0]  meta_len;
  logic [XW-1:0]  meta_x, meta_y;
  logic [FBW-1:0] meta_f;
  logic           dst_rdy = 1'b1;
  logic           h_req_val, c_req_val;
  logic [FW-1:0]  h_req_addr, c_req_addr;
  logic           h_rdy = 1'b1, c_rdy = 1'b1;
  logic           h_resp_val = 1'b0, c_resp_val = 1'b0;
  logic [PW:0]    h_resp_data = '0, c_resp_data = '0;
  logic           h_resp_rdy, c_resp_rdy;

  tcp_rx_app_msg_poller dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .src_poller_msg_req_val      (req_val),
    .src_poller_msg_req_flowid   (req_flowid),
    .src_poller_msg_req_len      (req_len),
    .src_poller_msg_dst_x        (req_x),
    .src_poller_msg_dst_y        (req_y),
    .src_poller_msg_dst_fbits    (req_f),
    .poller_src_msg_req_rdy      (req_rdy),
    .poller_msg_dst_meta_val     (meta_val),
    .poller_msg_dst_flowid       (meta_flowid),
    .poller_msg_dst_base_ptr     (meta_base),
    .poller_msg_dst_len          (meta_len),
    .poller_msg_dst_dst_x        (meta_x),
    .poller_msg_dst_dst_y        (meta_y),
    .poller_msg_dst_dst_fbits    (meta_f),
    .dst_poller_msg_meta_rdy     (dst_rdy),
    .app_head_ptr_rd_req_val     (h_req_val),
    .app_head_ptr_rd_req_addr    (h_req_addr),
    .head_ptr_app_rd_req_rdy     (h_rdy),
    .head_ptr_app_rd_resp_val    (h_resp_val),
    .head_ptr_app_rd_resp_data   (h_resp_data),
    .app_head_ptr_rd_resp_rdy    (h_resp_rdy),
    .app_commit_ptr_rd_req_val   (c_req_val),
    .app_commit_ptr_rd_req_addr  (c_req_addr),
    .commit_ptr_app_rd_req_rdy   (c_rdy),
    .commit_ptr_app_rd_resp_val  (c_resp_val),
    .commit_ptr_app_rd_resp_data (c_resp_data),
    .app_commit_ptr_rd_resp_rdy  (c_resp_rdy)
  );

  logic [PW:0]   head_mem [256];
  logic [PW:0]   commit_mem [256];
  int            h_dly = 0, c_dly = 0;
  logic          mem_flush = 1'b0;
  logic          h_busy = 1'b0, c_busy = 1'b0;
  int            h_wait = 0, c_wait = 0;
  logic [FW-1:0] h_addr = '0, c_addr = '0;

  // Response appears h_dly cycles after the cycle following request accept.
  always @(posedge clk) begin
    if (mem_flush) begin
      h_resp_val <= 1'b0;
      h_busy     <= 1'b0;
    end else begin
      if (h_resp_val && h_resp_rdy) h_resp_val <= 1'b0;
      if (h_busy) begin
        if (h_wait == 0) begin
          h_resp_val  <= 1'b1;
          h_resp_data <= head_mem[h_addr];
          h_busy      <= 1'b0;
        end else h_wait <= h_wait - 1;
      end
      if (h_req_val && h_rdy) begin
        if (h_dly == 0) begin
          h_resp_val  <= 1'b1;
          h_resp_data <= head_mem[h_req_addr];
        end else begin
          h_busy <= 1'b1;
          h_wait <= h_dly - 1;
          h_addr <= h_req_addr;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (mem_flush) begin
      c_resp_val <= 1'b0;
      c_busy     <= 1'b0;
    end else begin
      if (c_resp_val && c_resp_rdy) c_resp_val <= 1'b0;
      if (c_busy) begin
        if (c_wait == 0) begin
          c_resp_val  <= 1'b1;
          c_resp_data <= commit_mem[c_addr];
          c_busy      <= 1'b0;
        end else c_wait <= c_wait - 1;
      end
      if (c_req_val && c_rdy) begin
        if (c_dly == 0) begin
          c_resp_val  <= 1'b1;
          c_resp_data <= commit_mem[c_req_addr];
        end else begin
          c_busy <= 1'b1;
          c_wait <= c_dly - 1;
          c_addr <= c_req_addr;
        end
      end
    end
  end

  int head_fires = 0, meta_fires = 0;
  always @(posedge clk) begin
    if (h_req_val && h_rdy) head_fires++;
    if (meta_val && dst_rdy) meta_fires++;
  end

  int vecs = 0, miscmp = 0;
  logic [FW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    vecs++;
    miscmp++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic send_req(input logic [FW-1:0] fl, input logic [PW-1:0] ln,
                          input logic [XW-1:0] x, input logic [XW-1:0] y,
                          input logic [FBW-1:0] fb);
    int n;
    n = 0;
    @(negedge clk);
    req_val = 1'b1; req_flowid = fl; req_len = ln;
    req_x = x; req_y = y; req_f = fb;
    while (!req_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail("req_rdy_wait");
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic wait_meta(output int lat);
    lat = 0;
    while (!meta_val && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!meta_val) timeout_fail("meta_wait");
  endtask

  task automatic set_flow(input int fl, input logic [PW:0] hd, input logic [PW:0] cm);
    head_mem[fl]   = hd;
    commit_mem[fl] = cm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, f0, m0, n, rdy_hi, bad, idx;
    logic stable;
    for (int i = 0; i < 256; i++) set_flow(i, '0, '0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_meta_val", meta_val, 0);
    chk("rst_h_req_val", h_req_val, 0);
    chk("rst_c_req_val", c_req_val, 0);
    chk("rst_h_resp_rdy", h_resp_rdy, 0);
    chk("rst_base_ptr", meta_base, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_rdy", req_rdy, 1);

    // Satisfied on first poll, minimum latency
    set_flow(3, 15'h0100, 15'h0140);
    send_req(8'd3, 14'h0040, 8'd1, 8'd2, 4'd3);
    wait_meta(lat);
    chk("t1_latency", lat, 4);
    chk("t1_flowid", meta_flowid, 3);
    chk("t1_base", meta_base, 15'h0100);
    chk("t1_len", meta_len, 14'h0040);
    chk("t1_dst_x", meta_x, 1);
    chk("t1_dst_y", meta_y, 2);
    chk("t1_fbits", meta_f, 3);
    @(negedge clk);
    chk("t1_meta_drop", meta_val, 0);
    f0 = head_fires;
    repeat (8) @(negedge clk);
    chk("t1_no_repoll", head_fires - f0, 0);
    chk("t1_meta_count", meta_fires, 1);

    // Requeue until the commit pointer advances
    set_flow(5, 15'h0000, 15'h0010);
    f0 = head_fires;
    send_req(8'd5, 14'h0020, 8'd4, 8'd5, 4'd6);
    repeat (30) @(negedge clk);
    chk("t2_no_meta", meta_fires, 1);
    chk("t2_repolled", (head_fires - f0) >= 3, 1);
    commit_mem[5] = 15'h0020;
    wait_meta(lat);
    chk("t2_flowid", meta_flowid, 5);
    chk("t2_base", meta_base, 15'h0000);
    chk("t2_len", meta_len, 14'h0020);
    @(negedge clk);

    // Pointer wrap, full buffer and zero length
    set_flow(7, 15'h7FF0, 15'h0010);
    send_req(8'd7, 14'h0020, 8'd0, 8'd0, 4'd0);
    wait_meta(lat);
    chk("t3_wrap_lat", lat, 4);
    chk("t3_wrap_base", meta_base, 15'h7FF0);
    @(negedge clk);
    set_flow(8, 15'h6000, 15'h2000);
    send_req(8'd8, 14'h3FFF, 8'd0, 8'd0, 4'd0);
    wait_meta(lat);
    chk("t3_full_lat", lat, 4);
    chk("t3_full_base", meta_base, 15'h6000);
    @(negedge clk);
    set_flow(9, 15'h1234, 15'h1234);
    send_req(8'd9, 14'h0000, 8'd0, 8'd0, 4'd0);
    wait_meta(lat);
    chk("t3_len0_lat", lat, 4);
    chk("t3_len0_flowid", meta_flowid, 9);
    @(negedge clk);
    m0 = meta_fires;
    set_flow(10, 15'h7FF8, 15'h0017);
    send_req(8'd10, 14'h0020, 8'd0, 8'd0, 4'd0);
    repeat (15) @(negedge clk);
    chk("t3_one_short", meta_fires - m0, 0);
    commit_mem[10] = 15'h0018;
    wait_meta(lat);
    chk("t3_exact_base", meta_base, 15'h7FF8);
    @(negedge clk);

    // Fill: 8 unsatisfiable requests, backpressure, then drain all
    for (int k = 0; k < 8; k++) begin
      set_flow(20 + k, 15'(k * 256), 15'(k * 256));
      exp_q.push_back(8'(20 + k));
      send_req(8'(20 + k), 14'h0001, 8'(k), 8'd0, 4'd0);
    end
    chk("t4_rdy_low", req_rdy, 0);
    rdy_hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (req_rdy) rdy_hi++;
    end
    chk("t4_rdy_stays_low", rdy_hi, 0);
    m0 = meta_fires;
    for (int k = 0; k < 8; k++) commit_mem[20 + k] = 15'(k * 256 + 1);
    for (int i = 0; i < 8; i++) begin
      wait_meta(lat);
      idx = -1;
      foreach (exp_q[j]) if (exp_q[j] == meta_flowid) idx = j;
      chk("t4_flow_expected", idx >= 0, 1);
      chk("t4_base", meta_base, 32'((int'(meta_flowid) - 20) * 256));
      if (idx >= 0) exp_q.delete(idx);
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("t4_all_drained", exp_q.size(), 0);
    chk("t4_meta_count", meta_fires - m0, 8);
    chk("t4_rdy_back", req_rdy, 1);

    // Split request acceptance, commit response early, meta backpressure
    set_flow(30, 15'h0200, 15'h0300);
    h_dly = 2; c_dly = 0; dst_rdy = 1'b0; h_rdy = 1'b0;
    m0 = meta_fires;
    send_req(8'd30, 14'h0080, 8'd7, 8'd8, 4'd9);
    @(negedge clk);
    chk("t5_both_req", {h_req_val, c_req_val}, 2'b11);
    @(negedge clk);
    chk("t5_head_held", h_req_val, 1);
    chk("t5_commit_drop", c_req_val, 0);
    chk("t5_addr", h_req_addr, 30);
    h_rdy = 1'b1;
    wait_meta(lat);
    chk("t5_base", meta_base, 15'h0200);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(meta_val && meta_flowid == 8'd30 && meta_base == 15'h0200 &&
            meta_len == 14'h0080 && meta_x == 8'd7 && meta_y == 8'd8 &&
            meta_f == 4'd9)) stable = 1'b0;
    end
    chk("t5_stable", stable, 1);
    dst_rdy = 1'b1;
    @(negedge clk);
    chk("t5_meta_drop", meta_val, 0);
    repeat (5) @(negedge clk);
    chk("t5_one_meta", meta_fires - m0, 1);
    h_dly = 0;

    // Reset during RD_RESP with one request still queued
    set_flow(40, 15'h0010, 15'h0050);
    set_flow(41, 15'h0010, 15'h0050);
    h_dly = 6;
    send_req(8'd40, 14'h0010, 8'd0, 8'd0, 4'd0);
    send_req(8'd41, 14'h0010, 8'd0, 8'd0, 4'd0);
    n = 0;
    while (!h_resp_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!h_resp_rdy) timeout_fail("t6_reach_rd_resp");
    rst_n = 1'b0;
    #1;
    chk("t6_meta_val", meta_val, 0);
    chk("t6_req_vals", {h_req_val, c_req_val}, 2'b00);
    chk("t6_resp_rdys", {h_resp_rdy, c_resp_rdy}, 2'b00);
    chk("t6_req_rdy", req_rdy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (h_req_val || c_req_val || meta_val || h_resp_rdy || c_resp_rdy) bad++;
    end
    chk("t6_idle_after_reset", bad, 0);
    chk("t6_req_rdy_back", req_rdy, 1);
    mem_flush = 1'b1;
    @(negedge clk);
    mem_flush = 1'b0;
    h_dly = 0;
    send_req(8'd3, 14'h0040, 8'd1, 8'd2, 4'd3);
    wait_meta(lat);
    chk("t6_fresh_lat", lat, 4);
    chk("t6_fresh_base", meta_base, 15'h0100);
    chk("t6_fresh_flowid", meta_flowid, 3);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
